dct_pipe_ctrl: RTL and testbench

//  Sequencer for the free-running 8-point DCT pipeline; its stage registers have no enables.

---
 rtl/dct_pipe_ctrl_pkg.sv | 8 +
 rtl/dct_pipe_ctrl_valid_sr.sv | 28 ++
 rtl/dct_pipe_ctrl.sv | 86 ++++++++
 tb/tb_dct_pipe_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dct_pipe_ctrl_pkg.sv
// dct_pipe_ctrl_pkg: state codes, row tag width and counter-width helper for the DCT controller
package dct_pipe_ctrl_pkg;
  localparam int ROW_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dct_pipe_ctrl_valid_sr.sv
// dct_valid_sr: LAT-deep shift of {valid, row tag} with synchronous clear
module dct_valid_sr #(
  parameter int LAT = 4,
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           in_v,
  input  logic [W-1:0]   in_tag,
  output logic [LAT-1:0] vld,
  output logic [W-1:0]   out_tag
);
  logic [W-1:0] tag [LAT];
  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      vld[0] <= in_v;
      tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end
  assign out_tag = tag[LAT-1];
endmodule

// File: rtl/dct_pipe_ctrl.sv
// dct_pipe_ctrl: row sequencer for the free-running 8-point DCT pipeline with FIFO credit flow control.
// Define DCT_CTRL_STATS_EN to build the saturating row/stall counters.
module dct_pipe_ctrl
  import dct_pipe_ctrl_pkg::*;
#(
  parameter int LAT = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_load,
  output logic [ROW_W-1:0] load_row,
  output logic             fifo_wr,
  output logic [ROW_W-1:0] fifo_wr_row,
  output logic             fifo_wr_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fifo_rd,
  output logic             busy,
  output logic [1:0]       state_o,
  output logic [31:0]      stat_rows,
  output logic [31:0]      stat_stall
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  state_t state, state_nx;
  logic [CW-1:0] credit, fifo_cnt;
  logic [ROW_W-1:0] row;
  logic [LAT-1:0] vld;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (en ? RUN : IDLE) :
               state == RUN   ? (flush || !en ? DRAIN : RUN) :
               state == DRAIN ? (!(|vld) && fifo_cnt == '0 ? IDLE : DRAIN) : IDLE;
  end
  always_comb begin
    in_ready = state == RUN && credit != '0;
    busy = state != IDLE || |vld || fifo_cnt != '0;
    state_o = state;
  end
  assign pipe_load = in_valid & in_ready;
  assign load_row = row;
  assign out_valid = fifo_cnt != '0;
  assign fifo_rd = out_valid & out_ready;
  assign fifo_wr = vld[LAT-1];
  assign fifo_wr_last = fifo_wr && fifo_wr_row == ROW_W'(ROWS - 1);
  // The row counter is held at zero while idle, so any partial block restarts at row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= CW'(FIFO_DEPTH);
      fifo_cnt <= '0;
      row <= '0;
    end else begin
      credit <= credit + CW'(fifo_rd) - CW'(pipe_load);
      fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(fifo_rd);
      row <= state == IDLE ? '0 : pipe_load ? (row == ROW_W'(ROWS - 1) ? '0 : row + 1'b1) : row;
    end
  end
  dct_valid_sr #(.LAT(LAT), .W(ROW_W)) u_sr (
    .clk(clk),
    .clr(reset),
    .in_v(pipe_load),
    .in_tag(row),
    .vld(vld),
    .out_tag(fifo_wr_row)
  );
  always_ff @(posedge clk) if (!reset) assert (32'(credit) + $countones(vld) + 32'(fifo_cnt) == FIFO_DEPTH);
`ifdef DCT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rows <= '0;
      stat_stall <= '0;
    end else begin
      if (pipe_load && !(&stat_rows)) stat_rows <= stat_rows + 1'b1;
      if (state == RUN && in_valid && !in_ready && !(&stat_stall)) stat_stall <= stat_stall + 1'b1;
    end
  end
`else
  assign stat_rows = '0;
  assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_dct_pipe_ctrl.sv
// tb_dct_pipe_ctrl: directed scenarios with a row-tag scoreboard on the FIFO write stream
module tb_dct_pipe_ctrl;
  localparam int LAT = 4;
  localparam int ROWS = 8;
  logic clk = 0, reset = 1, en = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, pipe_load, fifo_wr, fifo_wr_last, out_valid, fifo_rd, busy;
  logic [2:0] load_row, fifo_wr_row;
  logic [1:0] state_o;
  logic [31:0] stat_rows, stat_stall;
  int cyc = 0, errors = 0, checks = 0, exp_row = 0, wrs = 0, n, w0;
  typedef struct {int due; int row;} exp_t;
  exp_t q[$];

  dct_pipe_ctrl #(.LAT(LAT), .FIFO_DEPTH(8), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pipe_load(pipe_load), .load_row(load_row),
    .fifo_wr(fifo_wr), .fifo_wr_row(fifo_wr_row), .fifo_wr_last(fifo_wr_last),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_rd(fifo_rd), .busy(busy),
    .state_o(state_o), .stat_rows(stat_rows), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  // Each load books a write LAT cycles later carrying the bench's own row count.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (pipe_load) begin
        chk("load_row", load_row, exp_row);
        q.push_back('{cyc + LAT, exp_row});
        exp_row = (exp_row + 1) % ROWS;
      end
      if (fifo_wr) begin
        wrs++;
        if (q.size() == 0) chk("wr_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("wr_cycle", cyc, e.due);
          chk("wr_row", fifo_wr_row, e.row);
          chk("wr_last", fifo_wr_last, e.row == ROWS - 1);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("wr_missing", 0, 1);
        e = q.pop_front();
      end
    end
  end

  initial begin
    repeat (2) next;
    @(negedge clk);
    chk("rst_outs", {in_ready, pipe_load, load_row, fifo_wr, fifo_wr_row, fifo_wr_last,
                     out_valid, fifo_rd, busy, state_o}, 0);
    chk("rst_stats", {stat_rows, stat_stall}, 0);
    next; reset = 0; en = 1; out_ready = 1;
    @(negedge clk); chk("en_state0", state_o, 0);
    @(negedge clk); chk("run_state", state_o, 1); chk("run_ready", in_ready, 1);
    next; in_valid = 1;
    @(negedge clk); chk("s2_load", pipe_load, 1); chk("s2_row", load_row, 0);
    next; in_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); chk("s2_wr", fifo_wr, k == 4);
    end
    @(negedge clk); chk("s2_rd", fifo_rd, 1);
    next; in_valid = 1;
    repeat (9) begin
      @(negedge clk); chk("s3_ready", in_ready, 1); chk("s3_load", pipe_load, 1);
    end
    next; in_valid = 0;
    repeat (10) next;
    out_ready = 0; in_valid = 1; n = 0;
    repeat (12) begin
      @(negedge clk); n += int'(pipe_load);
    end
    chk("s4_loads", n, 8); chk("s4_blocked", in_ready, 0);
    next; out_ready = 1;
    @(negedge clk); chk("s4_rd", fifo_rd, 1); chk("s4_noreuse", in_ready, 0);
    next; out_ready = 0;
    @(negedge clk); chk("s4_reload", pipe_load, 1);
    next;
    @(negedge clk); chk("s4_blocked2", in_ready, 0);
    next; in_valid = 0; out_ready = 1;
    repeat (16) next;
    in_valid = 1;
    @(negedge clk); chk("s5_load1", pipe_load, 1);
    next;
    @(negedge clk); chk("s5_load2", pipe_load, 1);
    next; flush = 1;
    @(negedge clk); chk("s5_flush_accept", pipe_load, 1); w0 = wrs;
    next; flush = 0;
    @(negedge clk); chk("s5_ready", in_ready, 0); chk("s5_drain", state_o, 2);
    next; in_valid = 0;
    for (int i = 0; i < 40 && state_o != 2'd0; i++) @(negedge clk);
    chk("s5_idle", state_o, 0); chk("s5_writes", wrs - w0, 3);
    chk("s5_busy", busy, 0); chk("s5_empty", out_valid, 0);
    exp_row = 0;
    next; in_valid = 1;
    @(negedge clk); chk("s5_row0_load", pipe_load, 1); chk("s5_row0", load_row, 0);
    next;
    @(negedge clk); chk("s6_load2", pipe_load, 1);
    next; in_valid = 0; reset = 1;
    @(negedge clk);
    next; reset = 0; q.delete(); exp_row = 0;
    @(negedge clk); chk("s6_busy", busy, 0); chk("s6_outv", out_valid, 0); chk("s6_state", state_o, 0);
    next;
    next; out_ready = 0; in_valid = 1; n = 0;
    repeat (14) begin
      @(negedge clk); n += int'(pipe_load);
    end
    chk("s6_credit", n, 8);
    next; in_valid = 0;
    @(negedge clk);
`ifdef DCT_CTRL_STATS_EN
    chk("stat_rows", stat_rows, 8); chk("stat_stall", stat_stall, 6);
`else
    chk("stat_rows", stat_rows, 0); chk("stat_stall", stat_stall, 0);
`endif
    next; out_ready = 1;
    repeat (20) next;
    en = 0;
    for (int i = 0; i < 40 && state_o != 2'd0; i++) @(negedge clk);
    chk("end_state", state_o, 0); chk("end_busy", busy, 0); chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
